// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring shift-subtract iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         qbit_o
);

  logic [W:0] shifted;

  // Shift the next dividend bit in, subtract the divisor when it fits.
  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    // The kept remainder is always below 2^W, so dropping the top bit is safe.
    rem_o   = qbit_o ? W'(shifted - {1'b0, divisor_i}) : shifted[W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// the iteration and complete one cycle after the request.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    dvd_q;     // dividend magnitude, quotient bits shift in
  logic [XLEN-1:0]    dvs_q;     // divisor magnitude
  logic [XLEN-1:0]    rem_q;     // partial remainder
  logic [XLEN-1:0]    a_raw_q;   // original dividend, the div-by-zero remainder
  logic               is_rem_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               div0_q;
  logic               ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [XLEN-1:0]    result_q;
`ifdef DIV_EARLY_OUT_EN
  logic               early_q;
`endif

  logic               in_signed;
  logic               a_neg;
  logic               b_neg;
  logic [XLEN-1:0]    a_mag;
  logic [XLEN-1:0]    b_mag;
  logic               in_div0;
  logic               in_ovf;
  logic [XLEN-1:0]    step_rem;
  logic               step_qbit;
  logic [XLEN-1:0]    quo_mag;
  logic [XLEN-1:0]    quo;
  logic [XLEN-1:0]    rem;
  logic [XLEN-1:0]    final_res;

  div_step #(.W(XLEN)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[XLEN-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // Decode the incoming request: signedness, magnitudes and special cases.
  always_comb begin
    in_signed = (op_e'(op) == OP_DIV) || (op_e'(op) == OP_REM);
    a_neg     = in_signed && a[XLEN-1];
    b_neg     = in_signed && b[XLEN-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    in_div0   = (b == '0);
    in_ovf    = in_signed && (a == INT_MIN) && (b == '1);
  end

  // Final sign correction and special-case override, valid on the last step.
  // NOTE: every always_comb output is assigned a default before any branch so no latch is inferred.
  always_comb begin
    quo_mag = {dvd_q[XLEN-2:0], step_qbit};
    quo     = q_neg_q ? (~quo_mag + 1'b1) : quo_mag;
    rem     = r_neg_q ? (~step_rem + 1'b1) : step_rem;
    if (div0_q) begin
      quo = '1;
      rem = a_raw_q;
    end else if (ovf_q) begin
      quo = INT_MIN;
      rem = '0;
    end
    final_res = is_rem_q ? rem : quo;
  end

  // Control FSM, datapath registers and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      a_raw_q  <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef DIV_EARLY_OUT_EN
      early_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
`ifdef DIV_EARLY_OUT_EN
          if (early_q) begin
            early_q  <= 1'b0;
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= final_res;
          end else
`endif
          if (start) begin
            dvd_q    <= a_mag;
            dvs_q    <= b_mag;
            rem_q    <= '0;
            a_raw_q  <= a;
            cnt_q    <= '0;
            is_rem_q <= op[1];
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            div0_q   <= in_div0;
            ovf_q    <= in_ovf;
`ifdef DIV_EARLY_OUT_EN
            if (in_div0 || in_ovf) begin
              early_q <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
`else
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
`endif
          end
        end
        S_CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[XLEN-2:0], step_qbit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_res;
            cnt_q    <= '0;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int   SP_LAT  = 1;
  localparam logic SP_BUSY = 1'b0;
`else
  localparam int   SP_LAT  = 32;
  localparam logic SP_BUSY = 1'b1;
`endif

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .Clk    (Clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one request, scramble inputs after acceptance, and watch for the done pulse.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input int exp_lat, input logic exp_busy);
    int done_at;
    int pulses;
    logic busy_first;
    @(negedge Clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    busy_first = busy;
    op = o ^ 2'b01; a = ~x; b = y + 32'd1;
    done_at = -1;
    pulses = 0;
    for (int i = 1; i <= 36; i++) begin
      @(posedge Clk); #1;
      if (done) begin
        pulses++;
        if (done_at < 0) done_at = i;
      end
    end
    check({tag, "_result"}, result, exp_res);
    check({tag, "_latency"}, 32'(done_at), 32'(exp_lat));
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_busy_first"}, {31'd0, busy_first}, {31'd0, exp_busy});
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #3 reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge Clk);
    reset = 1'b1;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 32, 1'b1);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32, 1'b1);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 1'b1);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 1'b1);
    do_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32, 1'b1);
    do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32, 1'b1);
    do_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 32, 1'b1);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32, 1'b1);
    do_op("remu_big_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32, 1'b1);
    do_op("divu_min_max", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32, 1'b1);
    do_op("remu_min_max", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32, 1'b1);

    do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SP_LAT, SP_BUSY);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, SP_LAT, SP_BUSY);
    do_op("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SP_LAT, SP_BUSY);
    do_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SP_LAT, SP_BUSY);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT, SP_BUSY);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SP_LAT, SP_BUSY);

    // start held high during CALC and again during DONE must be ignored
    @(negedge Clk);
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk); #1;
      if (done) pulses++;
      if (i == 5) begin start = 1'b1; a = 32'd9; b = 32'd3; end
      if (i == 20) start = 1'b0;
      if (i == 32) start = 1'b1;
      if (i == 33) start = 1'b0;
    end
    check("ignore_start_result", result, 32'd14);
    check("ignore_start_pulses", 32'(pulses), 32'd1);
    check("ignore_start_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in the 10th CALC cycle
    @(negedge Clk);
    op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("midcalc_reset_busy", {31'd0, busy}, 32'd0);
    check("midcalc_reset_done", {31'd0, done}, 32'd0);
    check("midcalc_reset_result", result, 32'd0);
    @(negedge Clk);
    reset = 1'b1;
    do_op("after_reset_divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 32, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- Clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  32  dividend.
- b  input  32  divisor.
- busy  output  1  iteration in progress.
- done  output  1  one-cycle completion pulse.
- result  output  32  quotient or remainder.

REQ-002 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.

Function
REQ-003 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-004 In IDLE, start=1 at rising edge E SHALL latch a, b and op, then enter CALC with the iteration counter at 0.
REQ-005 CALC SHALL perform one radix-2 restoring shift-subtract step per cycle on unsigned magnitudes, 32 steps in total, then enter DONE at edge E+32.
REQ-006 busy SHALL be 1 exactly while in CALC, and 0 in IDLE and DONE.
REQ-007 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-008 result SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-009 start SHALL be ignored in CALC and DONE; operand or op changes after E SHALL NOT affect the result.
REQ-010 Signed ops (DIV/REM):
- divide on absolute values;
- negate the quotient when the operand signs differ;
- give the remainder the sign of the dividend.
REQ-011 Divide by zero (b=0) SHALL give quotient 0xFFFFFFFF and remainder = a, for both signed and unsigned ops.
REQ-012 Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0.
REQ-013 Unsigned ops SHALL treat all 32 bits as magnitude, with no sign correction.

Reset
REQ-014 reset=0 SHALL immediately, without waiting for Clk, force IDLE, busy=0, done=0, result=0 and counter=0, including mid-CALC.
REQ-015 The first start sampled after reset deasserts SHALL be accepted normally.

Configuration
REQ-016 Macro DIV_EARLY_OUT_EN, when defined:
- divide-by-zero and signed-overflow cases SHALL bypass CALC and enter DONE at edge E+1;
- busy SHALL stay 0 in these cases.
REQ-017 Without DIV_EARLY_OUT_EN, the special cases SHALL take the full E+32 latency and produce the same values as REQ-011 and REQ-012.

Structure
REQ-018 Shared package div_pkg SHALL hold:
- XLEN constant;
- op enum (DIV, DIVU, REM, REMU);
- FSM state enum.
REQ-019 One combinational sub-module, div_step, SHALL compute a single shift-subtract iteration:
- inputs: partial remainder, dividend bit, divisor;
- outputs: next remainder, quotient bit.
REQ-020 div_unit SHALL own the FSM, counter, sign handling and special cases.

Verification
REQ-021 DIVU a=100, b=7, start at E -> done=1 only in the cycle after E+32, result=14; repeat with REMU -> result=2.
REQ-022 DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
REQ-023 DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5; done after E+1 with DIV_EARLY_OUT_EN, after E+32 without.
REQ-024 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-025 DIVU 100/7 started, then start=1 with a=9, b=3 during CALC -> ignored; result=14, exactly one done pulse.
REQ-026 reset=0 at the 10th CALC cycle -> busy=0, done=0, result=0 immediately; after release, DIVU 9/3 -> result=3.
